// File: rtl/sync_debounce.sv
// sync_debounce: glitch filter and edge detector for an already-synchronized bit.
// The accepted level flips only after the input has differed from it for
// STABLE_CYCLES consecutive enabled cycles. Rise/fall pulses and a saturating
// rising-event counter are produced in the same cycle the level flips.
module sync_debounce #(
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0,
  parameter int   CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             serial_i,
  input  logic             cnt_clr_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  // Last count value of a pending run; reaching it with a still-differing
  // input accepts the new level on this edge.
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // stab_q == 0 is the STABLE state, any non-zero value is PENDING.
  logic [SW-1:0]    stab_q, stab_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             accept;

  // State register: filter state plus registered pulses and counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stab_q  <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stab_q  <= stab_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: advance or abandon the pending run, accept on the last count.
  always_comb begin
    stab_d  = stab_q;
    level_d = level_q;
    accept  = 1'b0;
    if (!en_i) begin
      stab_d = '0;
    end else if (serial_i == level_q) begin
      // Input fell back to the accepted level: a rejected glitch, no pulse.
      stab_d = '0;
    end else if (stab_q == STAB_LAST) begin
      stab_d  = '0;
      level_d = serial_i;
      accept  = 1'b1;
    end else begin
      stab_d = stab_q + 1'b1;
    end
    rise_d   = accept & serial_i;
    fall_d   = accept & ~serial_i;
    // Clear takes effect before a same-cycle increment, so the result is 1.
    cnt_base = cnt_clr_i ? '0 : cnt_q;
    cnt_d    = (rise_d && (cnt_base != CNT_MAX)) ? cnt_base + 1'b1 : cnt_base;
  end

  // Outputs: straight from registers.
  always_comb begin
    level_o   = level_q;
    rise_o    = rise_q;
    fall_o    = fall_q;
    evt_cnt_o = cnt_q;
  end

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: two instances (STABLE_CYCLES=4/CNT_W=8 and
// STABLE_CYCLES=1/CNT_W=2) share stimulus. A history-queue model predicts
// every output; directed phases add literal checks, then random traffic runs.
module tb_sync_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       serial = 1'b1;
  logic       cnt_clr = 1'b0;
  logic       level0, rise0, fall0;
  logic [7:0] cnt0;
  logic       level1, rise1, fall1;
  logic [1:0] cnt1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_debounce #(.STABLE_CYCLES(4), .RESET_VAL(1'b0), .CNT_W(8)) u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .serial_i(serial), .cnt_clr_i(cnt_clr),
    .level_o(level0), .rise_o(rise0), .fall_o(fall0), .evt_cnt_o(cnt0));

  sync_debounce #(.STABLE_CYCLES(1), .RESET_VAL(1'b0), .CNT_W(2)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .serial_i(serial), .cnt_clr_i(cnt_clr),
    .level_o(level1), .rise_o(rise1), .fall_o(fall1), .evt_cnt_o(cnt1));

  // Model: per instance, the samples seen since the last disruption. The level
  // flips once the queue holds S samples that all differ from it.
  bit m_lvl[2];
  bit m_r[2];
  bit m_f[2];
  int m_cnt[2];
  bit hq[2][$];

  task automatic step(input int i, input int s, input int w);
    m_r[i] = 1'b0;
    m_f[i] = 1'b0;
    if (!en || serial == m_lvl[i]) begin
      hq[i].delete();
    end else begin
      hq[i].push_back(serial);
      if (hq[i].size() >= s) begin
        m_lvl[i] = serial;
        m_r[i]   = serial;
        m_f[i]   = !serial;
        hq[i].delete();
      end
    end
    if (cnt_clr) m_cnt[i] = 0;
    if (m_r[i] && m_cnt[i] < (1 << w) - 1) m_cnt[i] = m_cnt[i] + 1;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          m_lvl[i] = 1'b0;
          m_r[i]   = 1'b0;
          m_f[i]   = 1'b0;
          m_cnt[i] = 0;
          hq[i].delete();
        end
      end else begin
        step(0, 4, 8);
        step(1, 1, 2);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("u0.level", 32'(level0), 32'(m_lvl[0]));
      chk("u0.rise",  32'(rise0),  32'(m_r[0]));
      chk("u0.fall",  32'(fall0),  32'(m_f[0]));
      chk("u0.cnt",   32'(cnt0),   32'(m_cnt[0]));
      chk("u1.level", 32'(level1), 32'(m_lvl[1]));
      chk("u1.rise",  32'(rise1),  32'(m_r[1]));
      chk("u1.fall",  32'(fall1),  32'(m_f[1]));
      chk("u1.cnt",   32'(cnt1),   32'(m_cnt[1]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int run_left;

  initial begin
    // Reset held 3 cycles with serial high.
    tick(3);
    chk("rst.level", 32'(level0), 32'd0);
    chk("rst.rise",  32'(rise0),  32'd0);
    chk("rst.fall",  32'(fall0),  32'd0);
    chk("rst.cnt",   32'(cnt0),   32'd0);
    serial = 1'b0;
    rst    = 1'b0;
    tick(2);

    // Accepted rise then fall, 4 cycles after each change.
    serial = 1'b1;
    tick(3);
    chk("rise.early", 32'(level0), 32'd0);
    tick(1);
    chk("rise.level", 32'(level0), 32'd1);
    chk("rise.pulse", 32'(rise0),  32'd1);
    tick(1);
    chk("rise.once",  32'(rise0),  32'd0);
    tick(2);
    serial = 1'b0;
    tick(3);
    chk("fall.early", 32'(level0), 32'd1);
    tick(1);
    chk("fall.pulse", 32'(fall0),  32'd1);
    chk("fall.level", 32'(level0), 32'd0);
    chk("fall.cnt",   32'(cnt0),   32'd1);
    tick(2);

    // Glitches of 1..3 cycles separated by 5 low cycles.
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    for (int l = 1; l <= 3; l++) begin
      serial = 1'b1;
      tick(l);
      serial = 1'b0;
      tick(5);
    end
    chk("glitch.level", 32'(level0), 32'd0);
    chk("glitch.cnt",   32'(cnt0),   32'd0);

    // Enable dropped for one cycle mid-run restarts the run.
    serial = 1'b1;
    tick(2);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(3);
    chk("en.early", 32'(level0), 32'd0);
    tick(1);
    chk("en.rise",  32'(rise0),  32'd1);
    serial = 1'b0;
    tick(6);

    // Same interruption with reset.
    serial = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rstmid.level", 32'(level0), 32'd0);
    rst = 1'b0;
    tick(3);
    chk("rstmid.early", 32'(level0), 32'd0);
    tick(1);
    chk("rstmid.rise",  32'(rise0),  32'd1);
    serial = 1'b0;
    tick(6);

    // Saturation on the 2-bit counter, then clear with a coincident rise.
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      serial = 1'b1;
      tick(1);
      serial = 1'b0;
      tick(1);
    end
    chk("sat.cnt", 32'(cnt1), 32'd3);
    serial  = 1'b1;
    cnt_clr = 1'b1;
    tick(1);
    chk("clr.cnt",  32'(cnt1),  32'd1);
    chk("clr.rise", 32'(rise1), 32'd1);
    cnt_clr = 1'b0;
    tick(1);

    // Random traffic with runs of 1..7 cycles.
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        serial   = ~serial;
        run_left = $urandom_range(1, 7);
      end
      run_left = run_left - 1;
      en      = ($urandom_range(0, 15) != 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    en  = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
